// File: rtl/imem_responder_if.sv
// Fetch-side request/response and boot-loader load port of the instruction memory responder.
// The master modport is the fetch stage plus loader; the slave modport is the responder.
interface imem_responder_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] imem_rsp_addr;
    logic        imem_fault;
    logic        load_start;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_done;

    modport master (
        output imem_addr, load_start, load_valid, load_data, load_last,
        input  imem_data, imem_rsp_addr, imem_fault, load_ready, load_done
    );

    modport slave (
        input  imem_addr, load_start, load_valid, load_data, load_last,
        output imem_data, imem_rsp_addr, imem_fault, load_ready, load_done
    );
endinterface

// File: rtl/imem_responder.sv
// Word-addressed instruction store: filled by a boot loader over a valid/ready port,
// then answers fetch addresses with a one-cycle registered read.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           reset,
    imem_responder_if.slave                bus,
    output logic                           busy,
    output logic [$clog2(DEPTH_WORDS):0]   word_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word;
    logic          rd_hit;

    logic [31:0]   off;
    logic [29:0]   idx;
    logic          addr_ok;
    logic          accept;
    logic          last_beat;

    always_comb begin
        off       = bus.imem_addr - BASE_ADDR;
        idx       = off[31:2];
        // word_count never exceeds DEPTH_WORDS, so this also rejects out-of-store indices.
        addr_ok   = (off[1:0] == 2'b00) && (idx < 30'(word_count));
        accept    = (state == LOAD) && bus.load_valid;
        last_beat = bus.load_last || (ptr == AW'(DEPTH_WORDS - 1));
    end

    assign bus.load_ready = (state == LOAD);
    assign busy           = (state == LOAD);

    // Only a hit exposes the stored word; everything else (reset, IDLE, LOAD, faults) is a NOP.
    assign bus.imem_data  = rd_hit ? rd_word : NOP_INSTR;

    // NOTE: the store has no reset so it maps onto block RAM; validity is tracked by word_count.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr] <= bus.load_data;
        end
        rd_word <= mem[idx[AW-1:0]];
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            ptr               <= '0;
            word_count        <= '0;
            rd_hit            <= 1'b0;
            bus.imem_fault    <= 1'b0;
            bus.imem_rsp_addr <= '0;
            bus.load_done     <= 1'b0;
        end else begin
            bus.imem_rsp_addr <= bus.imem_addr;
            rd_hit            <= 1'b0;
            bus.imem_fault    <= 1'b0;
            bus.load_done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.load_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        ptr <= ptr + 1'b1;
                        if (last_beat) begin
                            word_count    <= {1'b0, ptr} + CW'(1);
                            bus.load_done <= 1'b1;
                            state         <= RUN;
                        end
                    end
                end

                RUN: begin
                    rd_hit         <= addr_ok;
                    bus.imem_fault <= !addr_ok;
                    // The old word_count stays in force until the new load completes.
                    if (bus.load_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table vectors, hand-written load/reset sequences,
// and randomized fetch/reload traffic compared against an array-based reference model.
module tb_imem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          busy;
    logic [CW-1:0] word_count;

    imem_responder_if bus ();

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what the store holds and how many words are valid.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] load_words [DEPTH];
    int          model_wc  = 0;
    bit          model_run = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (!model_run) return {1'b0, NOP};
        if ((o % 4 == 0) && ((o / 4) < 32'(model_wc))) return {1'b0, model_mem[o / 4]};
        return {1'b1, NOP};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] i;
        i = 32'($urandom_range(0, DEPTH + 3));
        case ($urandom_range(0, 4))
            0:       return BASE + i * 4 + 32'($urandom_range(1, 3));
            1:       return $urandom();
            2:       return BASE + i * 4;
            default: return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the current imem_addr, checking the response against the pre-edge model.
    task automatic fetch_cycle(input string name);
        logic [32:0] e;
        logic [31:0] a;
        a = bus.imem_addr;
        e = ref_fetch(a);
        step();
        check({name, " data"}, bus.imem_data, e[31:0]);
        check({name, " fault"}, 32'(bus.imem_fault), 32'(e[32]));
        check({name, " rsp_addr"}, bus.imem_rsp_addr, a);
    endtask

    // gap_mode: 0 = valid every cycle, 1 = valid follows vpat, 2 = random gaps and stray load_start
    task automatic do_load(input int len, input bit use_last, input int gap_mode,
                           input logic [63:0] vpat);
        int k;
        bit done;
        bit v;
        bus.load_start = 1'b1;
        bus.imem_addr  = rand_addr();
        fetch_cycle("load start");
        bus.load_start = 1'b0;
        model_run      = 1'b0;
        check("word_count retained", 32'(word_count), 32'(model_wc));
        check("busy in load", 32'(busy), 32'd1);
        check("ready in load", 32'(bus.load_ready), 32'd1);
        k    = 0;
        done = 1'b0;
        for (int c = 0; c < 16 * DEPTH && !done; c++) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (c < 64) ? vpat[c] : 1'b1;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.load_valid = v;
            bus.load_data  = v ? load_words[k] : $urandom();
            bus.load_last  = v ? (use_last && k == len - 1) : 1'($urandom_range(0, 1));
            bus.load_start = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.imem_addr  = rand_addr();
            fetch_cycle("during load");
            if (v) begin
                model_mem[k] = load_words[k];
                k++;
                done = (use_last && k == len) || (k == DEPTH);
            end
            check("load_done", 32'(bus.load_done), 32'(done));
            check("load_ready", 32'(bus.load_ready), 32'(!done));
        end
        check("load within budget", 32'(done), 32'd1);
        model_wc  = k;
        model_run = 1'b1;
        check("word_count", 32'(word_count), 32'(k));
        check("busy after load", 32'(busy), 32'd0);
        // A beat offered after completion must be refused and must not touch the store.
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b0;
        bus.load_data  = $urandom();
        bus.imem_addr  = rand_addr();
        fetch_cycle("after load");
        check("load_done single pulse", 32'(bus.load_done), 32'd0);
        check("ready after load", 32'(bus.load_ready), 32'd0);
        bus.load_valid = 1'b0;
    endtask

    initial begin
        bus.imem_addr  = 32'h0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.load_last  = 1'b0;

        // Held in reset
        step();
        step();
        check("rst data", bus.imem_data, NOP);
        check("rst rsp_addr", bus.imem_rsp_addr, 32'h0);
        check("rst fault", 32'(bus.imem_fault), 32'd0);
        check("rst ready", 32'(bus.load_ready), 32'd0);
        check("rst done", 32'(bus.load_done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst word_count", 32'(word_count), 32'd0);

        // IDLE fetches return NOP without fault
        reset = 1'b1;
        for (int i = 0; i < 3; i++) fetch_cycle("idle");
        check("idle busy", 32'(busy), 32'd0);
        check("idle ready", 32'(bus.load_ready), 32'd0);

        // Four-beat program with valid toggling 1,0,1,1,0,1
        for (int i = 0; i < 4; i++) load_words[i] = 32'hA0 + 32'(i);
        do_load(4, 1'b1, 1, 64'b101101);

        // Table-driven fetches against the four-word program
        tbl[0] = '{32'h0,    32'hA0, 1'b0};
        tbl[1] = '{32'h4,    32'hA1, 1'b0};
        tbl[2] = '{32'h8,    32'hA2, 1'b0};
        tbl[3] = '{32'hC,    32'hA3, 1'b0};
        tbl[4] = '{32'h2,    NOP,    1'b1};
        tbl[5] = '{32'h10,   NOP,    1'b1};
        tbl[6] = '{32'h4000, NOP,    1'b1};
        tbl[7] = '{32'hC,    32'hA3, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.imem_addr = tbl[i].addr;
            step();
            check($sformatf("tbl%0d data", i), bus.imem_data, tbl[i].data);
            check($sformatf("tbl%0d fault", i), 32'(bus.imem_fault), 32'(tbl[i].fault));
            check($sformatf("tbl%0d rsp_addr", i), bus.imem_rsp_addr, tbl[i].addr);
        end

        // Full-depth load with load_last never asserted; starts from RUN
        for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom();
        do_load(DEPTH, 1'b0, 0, 64'h0);

        for (int i = 0; i < 200; i++) begin
            bus.imem_addr = rand_addr();
            fetch_cycle("run rand");
        end

        // Random reloads of random length with gaps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom();
            do_load((r == 2) ? DEPTH : $urandom_range(1, DEPTH), 1'b1, 2, 64'h0);
            for (int i = 0; i < 100; i++) begin
                bus.imem_addr = rand_addr();
                fetch_cycle("reload rand");
            end
        end

        // Reset asserted mid-LOAD after two beats
        bus.imem_addr  = 32'h44;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h1111_1111;
        step();
        bus.load_data  = 32'h2222_2222;
        step();
        bus.load_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async rst data", bus.imem_data, NOP);
        check("async rst rsp_addr", bus.imem_rsp_addr, 32'h0);
        check("async rst fault", 32'(bus.imem_fault), 32'd0);
        check("async rst ready", 32'(bus.load_ready), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst word_count", 32'(word_count), 32'd0);
        model_run = 1'b0;
        model_wc  = 0;
        step();
        reset = 1'b1;
        bus.imem_addr = 32'h0;
        fetch_cycle("post rst fetch");
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst word_count", 32'(word_count), 32'd0);
        check("post rst ready", 32'(bus.load_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
